// File: rtl/lpf_channel_scheduler_if.sv
// Request/response bus between the channel samplers and the shared lowpass scheduler.
interface lpf_channel_scheduler_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 9
) ();
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   ack;
  logic             out_valid;
  logic [CW-1:0]    out_ch;
  logic signed [W-1:0] out_data;
  logic             busy;

  modport master (
    output req, in_data,
    input  ack, out_valid, out_ch, out_data, busy
  );

  modport slave (
    input  req, in_data,
    output ack, out_valid, out_ch, out_data, busy
  );
endinterface

// File: rtl/lpf_channel_scheduler.sv
// One first-order (z+1)/(16z-14) lowpass datapath time-shared across NCH channels
// with a round-robin arbiter and per-channel state kept in a local register file.
module lpf_channel_scheduler #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned W     = 9,
  parameter int unsigned SHIFT = 3,
  parameter int unsigned ACC_W = W + 4
) (
  input  logic clk960kHz,
  input  logic rst_n,
  input  logic clr,
  lpf_channel_scheduler_if.slave bus
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [W-1:0]     x1_q  [NCH];
  logic signed [W-1:0]     x_q;
  logic [CW-1:0]           sel_q;
  logic [CW-1:0]           ptr_q;

  logic [NCH-1:0]          ack_q;
  logic                    out_valid_q;
  logic [CW-1:0]           out_ch_q;
  logic signed [W-1:0]     out_data_q;
  logic                    busy_q;

  logic [NCH-1:0]          req_eff_c;
  logic                    found_c;
  logic [CW-1:0]           pick_c;
  logic                    grant_c;
  logic signed [ACC_W-1:0] acc_sel_c;
  logic signed [ACC_W-1:0] temp_c;

  // (base + off) mod NCH for base, off < NCH
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NCH) s = s - NCH;
    return CW'(s);
  endfunction

  // A channel acked this cycle still holds req for its old sample; skip it once.
  assign req_eff_c = bus.req & ~ack_q;

  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found_c && req_eff_c[wrap_add(ptr_q, i)]) begin
        found_c = 1'b1;
        pick_c  = wrap_add(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clr && found_c) begin
          state_d = CALC;
          grant_c = 1'b1;
        end
      end
      CALC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk960kHz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // y*16 recurrence: acc' = x + x1 + acc - acc/8, wrapping in ACC_W bits
  assign acc_sel_c = acc_q[sel_q];
  assign temp_c    = ACC_W'(x_q) + ACC_W'(x1_q[sel_q]) + acc_sel_c - (acc_sel_c >>> SHIFT);

  always_ff @(posedge clk960kHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
        x1_q[c]  <= '0;
      end
      x_q         <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= (state_d == CALC);
      if (clr) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          acc_q[c] <= '0;
          x1_q[c]  <= '0;
        end
        x_q        <= '0;
        sel_q      <= '0;
        out_ch_q   <= '0;
        out_data_q <= '0;
      end else if (state_q == CALC) begin
        acc_q[sel_q]  <= temp_c;
        x1_q[sel_q]   <= x_q;
        out_data_q    <= W'(temp_c[ACC_W-1:4]);
        out_ch_q      <= sel_q;
        out_valid_q   <= 1'b1;
        ack_q[sel_q]  <= 1'b1;
        ptr_q         <= wrap_add(sel_q, 1);
      end
      if (grant_c) begin
        sel_q <= pick_c;
        x_q   <= bus.in_data[32'(pick_c) * W +: W];
      end
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Bench for lpf_channel_scheduler: randomized traffic against a transaction-level
// round-robin + filter-recurrence model held in plain integer arrays.
module tb_lpf_channel_scheduler;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  lpf_channel_scheduler_if #(.NCH(NCH), .W(W)) bus ();

  lpf_channel_scheduler #(.NCH(NCH), .W(W)) dut (
    .clk960kHz(clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NCH-1:0] req_v;
  int samp  [NCH];
  int acc_m [NCH];
  int x1_m  [NCH];
  int ptr_m;

  task automatic drive();
    logic [NCH*W-1:0] d;
    d = '0;
    for (int c = 0; c < NCH; c++) d[c*W +: W] = W'(samp[c]);
    bus.req     = req_v;
    bus.in_data = d;
  endtask

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // two's-complement wrap into 13 bits
  function automatic int wrap_acc(input int v);
    int m;
    m = v % 8192;
    if (m < 0) m = m + 8192;
    if (m >= 4096) m = m - 8192;
    return m;
  endfunction

  task automatic model_zero();
    for (int c = 0; c < NCH; c++) begin
      acc_m[c] = 0;
      x1_m[c]  = 0;
    end
  endtask

  task automatic model_serve(input int ch, output int exp_out);
    acc_m[ch] = wrap_acc(samp[ch] + x1_m[ch] + acc_m[ch] - floor_div(acc_m[ch], 8));
    x1_m[ch]  = samp[ch];
    exp_out   = floor_div(acc_m[ch], 16);
    ptr_m     = (ch + 1) % NCH;
  endtask

  function automatic int model_pick();
    for (int i = 0; i < NCH; i++) begin
      if (req_v[(ptr_m + i) % NCH]) return (ptr_m + i) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] onehot(input int ch);
    return NCH'(1) << ch;
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    req_v = '0;
    for (int c = 0; c < NCH; c++) samp[c] = 0;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    ptr_m = 0;
  endtask

  // Observe only: wait up to budget cycles for the next out_valid.
  task automatic wait_service(input int budget, output bit got, output int ch, output int data,
                              output logic [NCH-1:0] ackv, output logic busy_before, output int ncyc);
    logic prev_busy;
    got = 1'b0; ch = -1; data = 0; ackv = '0; busy_before = 1'b0; ncyc = budget;
    prev_busy = bus.busy;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        got = 1'b1;
        ch = int'(bus.out_ch);
        data = int'(bus.out_data);
        ackv = bus.ack;
        busy_before = prev_busy;
        ncyc = i;
        break;
      end
      prev_busy = bus.busy;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (bus.ack !== '0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", bus.ack); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_ch !== '0) begin n_fail++; $display("FAIL reset_out_ch got %0d exp 0", bus.out_ch); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0d exp 0", bus.out_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_constant_input(input int ch, input int x, input int n,
                                     input int exp1, input int exp2, input int exp_final);
    bit got; int och, od, e, nc; logic [NCH-1:0] ak; logic bb;
    do_reset();
    req_v[ch] = 1'b1;
    samp[ch] = x;
    drive();
    od = 0;
    for (int k = 0; k < n; k++) begin
      wait_service(10, got, och, od, ak, bb, nc);
      n_checks++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL const_timeout ch=%0d k=%0d", ch, k); return; end
      model_serve(ch, e);
      n_checks++; if (och !== ch) begin n_fail++; $display("FAIL const_ch k=%0d got %0d exp %0d", k, och, ch); end
      n_checks++; if (od !== e) begin n_fail++; $display("FAIL const_data ch=%0d k=%0d got %0d exp %0d", ch, k, od, e); end
      n_checks++; if (ak !== onehot(ch)) begin n_fail++; $display("FAIL const_ack k=%0d got %b exp %b", k, ak, onehot(ch)); end
      n_checks++; if (bb !== 1'b1) begin n_fail++; $display("FAIL const_busy k=%0d got %b exp 1", k, bb); end
      n_checks++; if (nc !== ((k == 0) ? 2 : 3)) begin n_fail++; $display("FAIL const_latency k=%0d got %0d exp %0d", k, nc, (k == 0) ? 2 : 3); end
      if (k == 0) begin
        n_checks++; if (od !== exp1) begin n_fail++; $display("FAIL const_first got %0d exp %0d", od, exp1); end
      end
      if (k == 1) begin
        n_checks++; if (od !== exp2) begin n_fail++; $display("FAIL const_second got %0d exp %0d", od, exp2); end
      end
    end
    n_checks++; if (od !== exp_final) begin n_fail++; $display("FAIL const_final ch=%0d got %0d exp %0d", ch, od, exp_final); end
    req_v = '0;
    drive();
    repeat (3) @(negedge clk);
  endtask

  // Channels other than the one just filtered must still start from zero state.
  task automatic test_isolation(input int used_ch);
    bit got; int och, od, nc; logic [NCH-1:0] ak; logic bb;
    for (int c = 0; c < NCH; c++) begin
      if (c == used_ch) continue;
      req_v = onehot(c);
      samp[c] = 100;
      drive();
      wait_service(10, got, och, od, ak, bb, nc);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL iso_timeout ch=%0d", c); end
      n_checks++; if (od !== 6) begin n_fail++; $display("FAIL iso_data ch=%0d got %0d exp 6", c, od); end
      n_checks++; if (och !== c) begin n_fail++; $display("FAIL iso_ch got %0d exp %0d", och, c); end
      req_v = '0;
      drive();
    end
  endtask

  task automatic test_round_robin();
    bit got; int och, od, e, nc, pc; logic [NCH-1:0] ak; logic bb;
    do_reset();
    req_v = '1;
    for (int c = 0; c < NCH; c++) samp[c] = rand_sample();
    drive();
    for (int k = 0; k < 40; k++) begin
      wait_service(10, got, och, od, ak, bb, nc);
      n_checks++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL rr_timeout k=%0d", k); return; end
      pc = model_pick();
      n_checks++; if (och !== pc) begin n_fail++; $display("FAIL rr_ch k=%0d got %0d exp %0d", k, och, pc); end
      n_checks++; if (och !== k % NCH) begin n_fail++; $display("FAIL rr_order k=%0d got %0d exp %0d", k, och, k % NCH); end
      model_serve(pc, e);
      n_checks++; if (od !== e) begin n_fail++; $display("FAIL rr_data k=%0d got %0d exp %0d", k, od, e); end
      n_checks++; if (ak !== onehot(pc)) begin n_fail++; $display("FAIL rr_ack k=%0d got %b exp %b", k, ak, onehot(pc)); end
      n_checks++; if (nc !== 2) begin n_fail++; $display("FAIL rr_gap k=%0d got %0d exp 2", k, nc); end
      samp[pc] = rand_sample();
      drive();
    end
    req_v = '0;
    drive();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pointer();
    bit got; int och, od, e, nc; logic [NCH-1:0] ak; logic bb;
    do_reset();
    req_v = 4'b0100;
    samp[2] = rand_sample();
    drive();
    wait_service(10, got, och, od, ak, bb, nc);
    model_serve(2, e);
    n_checks++; if (och !== 2) begin n_fail++; $display("FAIL ptr_first got %0d exp 2", och); end
    req_v = 4'b0101;
    samp[0] = rand_sample();
    samp[2] = rand_sample();
    drive();
    wait_service(10, got, och, od, ak, bb, nc);
    n_checks++; if (och !== 0) begin n_fail++; $display("FAIL ptr_wrap got %0d exp 0", och); end
    model_serve(0, e);
    n_checks++; if (od !== e) begin n_fail++; $display("FAIL ptr_wrap_data got %0d exp %0d", od, e); end
    req_v = 4'b0100;
    drive();
    wait_service(10, got, och, od, ak, bb, nc);
    n_checks++; if (och !== 2) begin n_fail++; $display("FAIL ptr_second got %0d exp 2", och); end
    model_serve(2, e);
    n_checks++; if (od !== e) begin n_fail++; $display("FAIL ptr_second_data got %0d exp %0d", od, e); end
    n_checks++; if (nc !== 2) begin n_fail++; $display("FAIL ptr_gap got %0d exp 2", nc); end
    req_v = '0;
    drive();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clr();
    bit got; int och, od, e, nc, pc; logic [NCH-1:0] ak; logic bb;
    do_reset();
    req_v = 4'b0010;
    samp[1] = 100;
    drive();
    for (int k = 0; k < 60; k++) begin
      wait_service(10, got, och, od, ak, bb, nc);
      model_serve(1, e);
    end
    n_checks++; if (od !== 100) begin n_fail++; $display("FAIL clr_settle got %0d exp 100", od); end
    // ch1 still requesting: skipped once, granted, then cleared while in CALC
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy got %b exp 1", bus.busy); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_zero();
    n_checks++; if (bus.ack !== '0) begin n_fail++; $display("FAIL clr_ack got %b exp 0", bus.ack); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %b exp 0", bus.out_valid); end
    wait_service(10, got, och, od, ak, bb, nc);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL clr_reserve_timeout"); end
    n_checks++; if (och !== 1) begin n_fail++; $display("FAIL clr_reserve_ch got %0d exp 1", och); end
    n_checks++; if (od !== 6) begin n_fail++; $display("FAIL clr_reserve_data got %0d exp 6", od); end
    n_checks++; if (ak !== 4'b0010) begin n_fail++; $display("FAIL clr_reserve_ack got %b exp 0010", ak); end
    model_serve(1, e);
    // clr while idle with a new requester: no grant that cycle, state wiped
    req_v[0] = 1'b1;
    samp[0] = 50;
    drive();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_zero();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle_busy got %b exp 0", bus.busy); end
    for (int k = 0; k < 2; k++) begin
      wait_service(10, got, och, od, ak, bb, nc);
      pc = model_pick();
      model_serve(pc, e);
      n_checks++; if (och !== pc) begin n_fail++; $display("FAIL clr_idle_ch k=%0d got %0d exp %0d", k, och, pc); end
      n_checks++; if (od !== e) begin n_fail++; $display("FAIL clr_idle_data k=%0d got %0d exp %0d", k, od, e); end
      req_v[pc] = 1'b0;
      drive();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    bit got; int och, od, e, nc, pc, last, exp_nc; logic [NCH-1:0] ak; logic bb;
    do_reset();
    for (int c = 0; c < NCH; c++) samp[c] = rand_sample();
    req_v = NCH'($urandom_range(1, (1 << NCH) - 1));
    drive();
    last = -1;
    for (int k = 0; k < 150; k++) begin
      exp_nc = (last >= 0 && req_v == onehot(last)) ? 3 : 2;
      wait_service(10, got, och, od, ak, bb, nc);
      n_checks++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL rand_timeout k=%0d", k); return; end
      pc = model_pick();
      model_serve(pc, e);
      n_checks++; if (och !== pc) begin n_fail++; $display("FAIL rand_ch k=%0d got %0d exp %0d", k, och, pc); end
      n_checks++; if (od !== e) begin n_fail++; $display("FAIL rand_data k=%0d got %0d exp %0d", k, od, e); end
      n_checks++; if (ak !== onehot(pc)) begin n_fail++; $display("FAIL rand_ack k=%0d got %b exp %b", k, ak, onehot(pc)); end
      n_checks++; if (nc !== exp_nc) begin n_fail++; $display("FAIL rand_gap k=%0d got %0d exp %0d", k, nc, exp_nc); end
      last = pc;
      if ($urandom_range(0, 1) == 0) req_v[pc] = 1'b0;
      else samp[pc] = rand_sample();
      for (int c = 0; c < NCH; c++) begin
        if (c != pc && !req_v[c] && $urandom_range(0, 2) == 0) begin
          req_v[c] = 1'b1;
          samp[c] = rand_sample();
        end
      end
      if (req_v == '0) begin
        pc = int'($urandom_range(0, NCH - 1));
        req_v[pc] = 1'b1;
        samp[pc] = rand_sample();
      end
      drive();
    end
    req_v = '0;
    drive();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit got; int och, od, e, nc; logic [NCH-1:0] ak; logic bb;
    do_reset();
    req_v = 4'b1000;
    samp[3] = 100;
    drive();
    for (int k = 0; k < 2; k++) begin
      wait_service(10, got, och, od, ak, bb, nc);
      model_serve(3, e);
    end
    n_checks++; if (od !== 18) begin n_fail++; $display("FAIL arst_pre_data got %0d exp 18", od); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy got %b exp 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy_clr got %b exp 0", bus.busy); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL arst_data got %0d exp 0", bus.out_data); end
    n_checks++; if (bus.out_ch !== '0) begin n_fail++; $display("FAIL arst_ch got %0d exp 0", bus.out_ch); end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.ack !== '0) begin n_fail++; $display("FAIL arst_pulse got valid=%b ack=%b exp 0", bus.out_valid, bus.ack); end
    @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    ptr_m = 0;
    wait_service(10, got, och, od, ak, bb, nc);
    n_checks++; if (od !== 6 || och !== 3) begin n_fail++; $display("FAIL arst_restart got ch=%0d data=%0d exp ch=3 data=6", och, od); end
    req_v = '0;
    drive();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_constant_input(0, 100, 60, 6, 18, 100);
    test_isolation(0);
    test_constant_input(1, -100, 60, -7, -18, -100);
    test_isolation(1);
    test_round_robin();
    test_pointer();
    test_clr();
    test_constant_input(2, -256, 70, -16, -46, -256);
    test_constant_input(3, 255, 70, 15, 45, 255);
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lpf_channel_scheduler.md
Name: lpf_channel_scheduler

Overview:
Time-multiplexed controller that shares one first-order lowpass datapath across NCH independent 60 kHz sample channels. The datapath implements the recurrence (z+1)/(16z-14). Per-channel filter state (accumulator = 16*y, previous input) lives in a local register file. A round-robin arbiter picks which requester is served next, and the controller sequences load, compute and write-back for that channel. The block sits between the ADC-side channel samplers and downstream consumers, and replaces NCH separate filter instances.

Parameters:
NCH, 4, number of requesting channels (2..8)
W, 9, signed sample width (input and output)
SHIFT, 3, feedback shift (acc - acc>>>SHIFT); 3 gives pole 14/16
ACC_W, W+4, accumulator width; acc holds 16*y

Ports:
clk960kHz  in  1  system clock, 16x the 60 kHz sample rate
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of all channel state and any in-flight operation
req  in  NCH  per-channel sample request; held high with in_data stable until ack
in_data  in  NCH*W  flattened signed samples; channel c occupies bits [c*W +: W]
ack  out  NCH  one-cycle pulse: sample of that channel consumed
out_valid  out  1  one-cycle pulse: out_data/out_ch are valid
out_ch  out  clog2(NCH)  channel index of out_data
out_data  out  W  signed filtered sample, acc[ACC_W-1:4]
busy  out  1  high while FSM is in CALC

Behaviour:
- Reset (rst_n=0, async):
  - all acc[c], x1[c] = 0
  - ack, out_valid, out_ch, out_data, busy = 0
  - FSM = IDLE; round-robin pointer = 0 (ch0 highest priority)
- FSM states: IDLE, CALC.
- IDLE: if clr=0 and any req bit is high:
  - grant the first requester at or after the pointer, searching upward with wrap
  - latch sel = granted channel and x = in_data[sel]
  - go to CALC (busy=1 next cycle)
  - otherwise stay in IDLE.
- CALC (exactly one cycle):
  - temp = sext(x) + sext(x1[sel]) + acc[sel] - (acc[sel] >>> SHIFT)
  - temp is computed in ACC_W bits, two's-complement wrap, no saturation; >>> is arithmetic (floor)
  - write back acc[sel] <= temp, x1[sel] <= x
  - out_data <= temp[ACC_W-1:4], out_ch <= sel
  - out_valid <= 1 and ack[sel] <= 1, both visible the cycle after CALC
  - pointer <= sel+1 mod NCH
  - go to IDLE
- Timing:
  - latency from req sampled in IDLE to ack/out_valid: 2 cycles
  - maximum throughput: one sample per 2 cycles; all 4 channels in 8 of the 16 cycles per 60 kHz period
- Handshake:
  - requester must hold req and data until ack; ack and out_valid coincide
  - after ack the requester drops req, or keeps it high to request a new sample (the next sample for that channel is granted no earlier than the cycle after ack)
  - req dropping before grant: nothing is recorded
- Simultaneous requests: resolved only by round robin. No channel waits more than NCH-1 services.
- clr:
  - in IDLE: zero all state; no grant that cycle
  - in CALC: abort; no write-back, no ack, no out_valid; zero all state; FSM returns to IDLE; the pending req is re-served later
  - the pointer is not reset by clr
- Only the selected channel's state changes in a service; other channels are untouched.
- Unused channel ordering: indices ≥ NCH are never granted.
- DC gain 1: constant x gives steady acc in [16x, 16x+7].

Test Plan:
- Reset, then req[0] held with x=100:
  - first out_data = 6 (acc=100), second = 18 (acc=288)
  - converges to 100, acc in [1600,1607]
  - ack[0] and out_valid coincide, 2 cycles after each grant
- Constant x=-100 on ch1 -> out_data settles at -100 (acc in [-1600,-1593]); ch0/2/3 state remains 0.
- req=4'b1111 held from reset:
  - service order 0,1,2,3,0,…, with out_valid every 2 cycles
  - out_ch matches; each ack pulses once per service
- Pointer=3 after serving ch2, then req=4'b0101 -> ch0 served before ch2; after ch0, only ch2 pending -> ch2 served next.
- clr asserted during CALC for ch1 with acc[1]=1600:
  - no ack/out_valid that cycle; all acc = 0
  - ch1 re-served later, giving out_data = 6 for x=100
- Extremes:
  - x = -256 constant -> acc settles ≥ -4096, no wrap, out = -256
  - x = 255 -> out = 255
  - async rst_n mid-CALC zeroes all outputs immediately.
